serial_inequality_comparator: RTL and testbench
===============================================

SERIAL_INEQUALITY_COMPARATOR -- requirements
Module: serial_inequality_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width in bits, at least 2.
REQ-002 The block SHALL have parameter DIGIT, default 1: bits examined per scan cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have parameter SIGNED, default 0: 1 selects two's-complement ordering, 0 selects unsigned ordering.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: requests a comparison; sampled only while idle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands, captured on the edge where start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a comparison is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse when results update.
REQ-010 The block SHALL have ports eq, neq, lt and gt, output, 1 bit each: result flags for the relation of a to b.

Function
REQ-011 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-012 IDLE with start=1 SHALL capture a and b into internal registers, clear the chunk index to 0, and move to SCAN.
REQ-013 Each SCAN cycle SHALL compare chunk j, bits [WIDTH-1-j*DIGIT -: DIGIT], starting from the most significant chunk (j=0).
REQ-014 At the first chunk with any differing bit, the FSM SHALL register gt/lt from the most significant differing bit of that chunk, set neq=1 and eq=0, and move to DONE (early termination).
REQ-015 If all N=WIDTH/DIGIT chunks match, the FSM SHALL register eq=1 and neq=lt=gt=0, and move to DONE.
REQ-016 When SIGNED=1 and the operand sign bits differ, the operand with sign bit 1 SHALL be the lesser; in every other case the ordering SHALL be unsigned.
REQ-017 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-018 Latency, counted from the start-accept edge to the cycle in which done is high, SHALL be j+1 cycles for a first difference in chunk j, and N cycles for equal operands.
REQ-019 busy SHALL be high in SCAN and DONE and low in IDLE.
REQ-020 start while busy=1 SHALL be ignored, with no queuing.
REQ-021 Changes on a and b after capture SHALL have no effect on the comparison in progress.
REQ-022 Result flags SHALL hold their last values until the next done cycle updates them.
REQ-023 Exactly one of eq, lt, gt SHALL be high after any completed comparison, and neq SHALL always equal ~eq.

Reset
REQ-024 reset=1 SHALL force IDLE and drive busy=0, done=0, eq=0, neq=0, lt=0, gt=0, and zero every internal register.
REQ-025 reset asserted in SCAN or DONE SHALL abort the operation with no done pulse.
REQ-026 reset SHALL take priority over start on the same edge.

Configuration
REQ-027 With macro INEQ_COMPARATOR_DIFF_MASK_EN defined, the block SHALL add output diff_mask, WIDTH bits, registered as captured a ^ captured b and updated on the done cycle; its reset value SHALL be 0.
REQ-028 Without INEQ_COMPARATOR_DIFF_MASK_EN, the diff_mask port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 The state encodings IDLE=2'd0, SCAN=2'd1 and DONE=2'd2 SHALL live in the shared package comparator_pkg, together with the result-flag index constants.
REQ-030 The per-chunk comparison SHALL be a combinational sub-module chunk_compare (inputs: two DIGIT-bit chunks; outputs: differ, a_greater), instantiated once and fed by a chunk-select mux.

Verification (WIDTH=8, DIGIT=1, SIGNED=0 unless stated)
REQ-031 a=8'h15, b=8'h0A, start -> done 4 cycles after accept; gt=1, neq=1, eq=lt=0; diff_mask=8'h1F when the macro is enabled.
REQ-032 a=8'h3C, b=8'h3C -> done 8 cycles after accept; eq=1, neq=lt=gt=0; diff_mask=8'h00.
REQ-033 a=8'h80, b=8'h01: SIGNED=1 -> lt=1 with done 1 cycle after accept; SIGNED=0 -> gt=1 with done 1 cycle after accept.
REQ-034 Start accepted; start pulsed again 2 cycles later with different operands -> second start ignored; results match the first operands only.
REQ-035 reset asserted 3 cycles into a scan of a=8'h01, b=8'h00 -> no done pulse; all outputs 0; next start runs normally.
REQ-036 DIGIT=4, a=8'hA5, b=8'hA7 -> done 2 cycles after accept; lt=1.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared FSM encodings, result-flag indices and sizing helper for the serial comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned FLAG_EQ   = 0;
    localparam int unsigned FLAG_NEQ  = 1;
    localparam int unsigned FLAG_LT   = 2;
    localparam int unsigned FLAG_GT   = 3;
    localparam int unsigned NUM_FLAGS = 4;

    // Counter width for n chunks; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational compare of one DIGIT-bit chunk: any difference, and whether a wins
// at the most significant differing bit.
module chunk_compare #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] chunk_a,
    input  logic [DIGIT-1:0] chunk_b,
    output logic             differ,
    output logic             a_greater
);

    // Scan upward so the highest differing bit is the last one to write a_greater.
    always_comb begin
        differ    = 1'b0;
        a_greater = 1'b0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (chunk_a[i] != chunk_b[i]) begin
                differ    = 1'b1;
                a_greater = chunk_a[i];
            end
        end
    end

endmodule

// File: rtl/serial_inequality_comparator.sv
// Multi-cycle MSB-first comparator with early termination on the first differing chunk.
// Optional diff_mask output is enabled by defining INEQ_COMPARATOR_DIFF_MASK_EN.
module serial_inequality_comparator
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGIT  = 1,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             neq,
    output logic             lt,
    output logic             gt
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
    ,
    output logic [WIDTH-1:0] diff_mask
`endif
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned IDX_W = idx_width(N);
    localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
    logic [WIDTH-1:0]       mask_q, mask_d;
`endif

    logic [31:0]            sel_shift;
    logic [DIGIT-1:0]       chunk_a, chunk_b;
    logic                   differ, a_greater;

    // Chunk-select mux; flipping both sign bits turns two's-complement order into unsigned order.
    always_comb begin
        sel_shift = (N - 1 - 32'(idx_q)) * DIGIT;
        chunk_a   = DIGIT'(a_q >> sel_shift);
        chunk_b   = DIGIT'(b_q >> sel_shift);
        if (SIGNED != 0 && idx_q == '0) begin
            chunk_a = chunk_a ^ MSB_MASK;
            chunk_b = chunk_b ^ MSB_MASK;
        end
    end

    chunk_compare #(
        .DIGIT(DIGIT)
    ) u_chunk_compare (
        .chunk_a  (chunk_a),
        .chunk_b  (chunk_b),
        .differ   (differ),
        .a_greater(a_greater)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        flags_d = flags_q;
        done_d  = 1'b0;
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (differ || idx_q == IDX_W'(N - 1)) begin
                    flags_d = '0;
                    if (differ) begin
                        flags_d[FLAG_NEQ] = 1'b1;
                        flags_d[FLAG_GT]  = a_greater;
                        flags_d[FLAG_LT]  = ~a_greater;
                    end else begin
                        flags_d[FLAG_EQ]  = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
                    mask_d  = a_q ^ b_q;
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = flags_q[FLAG_EQ];
    assign neq  = flags_q[FLAG_NEQ];
    assign lt   = flags_q[FLAG_LT];
    assign gt   = flags_q[FLAG_GT];
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
    assign diff_mask = mask_q;
`endif

endmodule

// File: tb/tb_serial_inequality_comparator.sv
// Scoreboard bench for serial_inequality_comparator: three instances
// (unsigned DIGIT=1, signed DIGIT=1, unsigned DIGIT=4) against an arithmetic reference model.
module tb_serial_inequality_comparator;

    typedef struct {
        logic       eq;
        logic       lt;
        logic       gt;
        int         lat;
        logic [7:0] mask;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_s [3];
    logic [7:0] a_s [3];
    logic [7:0] b_s [3];
    logic       busy_o [3];
    logic       done_o [3];
    logic       eq_o [3];
    logic       neq_o [3];
    logic       lt_o [3];
    logic       gt_o [3];
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
    logic [7:0] mask_o [3];
`endif

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_inequality_comparator #(.WIDTH(8), .DIGIT(1), .SIGNED(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
        .busy(busy_o[0]), .done(done_o[0]), .eq(eq_o[0]), .neq(neq_o[0]),
        .lt(lt_o[0]), .gt(gt_o[0])
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
        , .diff_mask(mask_o[0])
`endif
    );

    serial_inequality_comparator #(.WIDTH(8), .DIGIT(1), .SIGNED(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
        .busy(busy_o[1]), .done(done_o[1]), .eq(eq_o[1]), .neq(neq_o[1]),
        .lt(lt_o[1]), .gt(gt_o[1])
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
        , .diff_mask(mask_o[1])
`endif
    );

    serial_inequality_comparator #(.WIDTH(8), .DIGIT(4), .SIGNED(0)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]),
        .busy(busy_o[2]), .done(done_o[2]), .eq(eq_o[2]), .neq(neq_o[2]),
        .lt(lt_o[2]), .gt(gt_o[2])
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
        , .diff_mask(mask_o[2])
`endif
    );

    task automatic check(input string name, input int k, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", name, k, act, req, cyc);
        end
    endtask

    // Reference: plain integer ordering; latency from the position of the top differing bit.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input int digit, input bit sgn);
        exp_t       e;
        int         va;
        int         vb;
        logic [7:0] x;
        va = sgn ? int'($signed(a)) : int'(a);
        vb = sgn ? int'($signed(b)) : int'(b);
        e.eq   = (va == vb);
        e.lt   = (va < vb);
        e.gt   = (va > vb);
        x      = a ^ b;
        e.mask = x;
        e.lat  = 8 / digit;
        for (int p = 0; p < 8; p++)
            if (x[p]) e.lat = (7 - p) / digit + 1;
        e.acc  = 0;
        return e;
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int k, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = model(8'h00, 8'h00, 1, 1'b0);
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   ok;
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                if (done_o[k]) begin
                    pop_exp(k, e, ok);
                    if (!ok) check("unexpected_done", k, 1, 0);
                    else begin
                        check("eq", k, int'(eq_o[k]), int'(e.eq));
                        check("neq", k, int'(neq_o[k]), int'(!e.eq));
                        check("lt", k, int'(lt_o[k]), int'(e.lt));
                        check("gt", k, int'(gt_o[k]), int'(e.gt));
                        check("latency", k, cyc - e.acc, e.lat);
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
                        check("diff_mask", k, int'(mask_o[k]), int'(e.mask));
`endif
                    end
                end
            end
        end
    end

    task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   t;
        t = 0;
        while (busy_o[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy_o[k]) check("idle_timeout", k, 1, 0);
        a_s[k]     = a;
        b_s[k]     = b;
        start_s[k] = 1'b1;
        e     = model(a, b, (k == 2) ? 4 : 1, k == 1);
        e.acc = cyc + 1;
        push_exp(k, e);
        @(negedge clk);
        start_s[k] = 1'b0;
        check("busy_after_accept", k, int'(busy_o[k]), 1);
    endtask

    task automatic drain(input int k);
        int t;
        t = 0;
        while ((qsize(k) != 0 || busy_o[k]) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", k, qsize(k), 0);
    endtask

    task automatic check_all_zero(input string tag, input int k);
        check({tag, "_busy"}, k, int'(busy_o[k]), 0);
        check({tag, "_done"}, k, int'(done_o[k]), 0);
        check({tag, "_eq"},   k, int'(eq_o[k]), 0);
        check({tag, "_neq"},  k, int'(neq_o[k]), 0);
        check({tag, "_lt"},   k, int'(lt_o[k]), 0);
        check({tag, "_gt"},   k, int'(gt_o[k]), 0);
`ifdef INEQ_COMPARATOR_DIFF_MASK_EN
        check({tag, "_mask"}, k, int'(mask_o[k]), 0);
`endif
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            a_s[k]     = 8'h00;
            b_s[k]     = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_all_zero("reset", k);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(0, 8'h15, 8'h0A);
        issue(0, 8'h3C, 8'h3C);
        issue(0, 8'h80, 8'h01);
        issue(1, 8'h80, 8'h01);
        issue(1, 8'h01, 8'h80);
        issue(1, 8'hFF, 8'hFE);
        issue(2, 8'hA5, 8'hA7);
        issue(2, 8'h5A, 8'h5A);
        issue(2, 8'h10, 8'h20);
        for (int k = 0; k < 3; k++) drain(k);

        // Start while busy is ignored and operand changes do not leak in
        issue(0, 8'h02, 8'h03);
        @(negedge clk);
        a_s[0]     = 8'hFF;
        b_s[0]     = 8'h00;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        drain(0);
        repeat (3) @(negedge clk);

        // Reset mid-scan aborts with no done pulse
        issue(0, 8'h01, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("abort", 0);
        q0.delete();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_done", 0, int'(done_o[0]), 0);
        issue(0, 8'h01, 8'h00);
        drain(0);

        // Randomized traffic, biased toward equal and single-bit-different operands
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 30; n++) begin
                ra = 8'($urandom);
                case ($urandom_range(0, 3))
                    0:       rb = ra;
                    1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
                    default: rb = 8'($urandom);
                endcase
                issue(k, ra, rb);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
            end
            drain(k);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
